// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and constants for the interrupt controller
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_DFLT   = 32'h0000_0080;
  localparam int          VEC_STRIDE_DFLT = 4;

  // Cause width: ceil(log2(n)), never below one bit.
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - lowest-index-first priority encoder with any-valid flag
module intr_prio_enc #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  output logic [CW-1:0] idx,
  output logic          any
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = CW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: sync, pending, mask, priority, Intr/Inta/Eoi handshake
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          N          = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DFLT,
  parameter int          VEC_STRIDE = VEC_STRIDE_DFLT,
  parameter logic [N-1:0] MASK_RST  = '0,
  localparam int         CW         = cw_of(N)
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic [N-1:0]  Irq,
  input  logic          MaskWe,
  input  logic [N-1:0]  MaskIn,
  input  logic          Inta,
  input  logic          Eoi,
  output logic          Intr,
  output logic [CW-1:0] Cause,
  output logic [31:0]   Vector,
  output logic [N-1:0]  Pending,
  output logic [N-1:0]  Mask,
  output logic          InService
);

  state_t         state;
  logic [N-1:0]   s1, s2, s3;
  logic [N-1:0]   pend, mask_q;
  logic [N-1:0]   edges, eligible, clr;
  logic [CW-1:0]  win;
  logic           any;

  assign edges    = s2 & ~s3;
  assign eligible = pend & ~mask_q;
  assign Pending  = pend;
  assign Mask     = mask_q;

  intr_prio_enc #(.N(N), .CW(CW)) u_enc (
    .req (eligible),
    .idx (win),
    .any (any)
  );

  // Only the committed cause is cleared, and only on the acknowledge.
  always_comb begin
    clr = '0;
    if (state == REQ && Inta) clr[Cause] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      pend   <= '0;
      mask_q <= MASK_RST;
    end else begin
      s1   <= Irq;
      s2   <= s1;
      s3   <= s2;
      pend <= (pend & ~clr) | edges;
      if (MaskWe) mask_q <= MaskIn;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state     <= IDLE;
      Intr      <= 1'b0;
      InService <= 1'b0;
      Cause     <= '0;
      Vector    <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            Cause  <= win;
            Vector <= VEC_BASE + 32'(win) * 32'(VEC_STRIDE);
            Intr   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (Inta) begin
            Intr      <= 1'b0;
            InService <= 1'b1;
            state     <= SERVICE;
          end
        end
        SERVICE: begin
          if (Eoi) begin
            InService <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          Intr      <= 1'b0;
          InService <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
